// File: rtl/v_storeu_if.sv
// Request, status and bank-write bundle for the vector store unit.
// The master drives the request; the slave (v_storeu) drives the bank writes and status.
interface v_storeu_if #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned GrpW  = 512
);
  logic                       start;
  logic [3:0]                 lsu_op;
  logic [2:0]                 lmul;
  logic [2:0]                 vsew;
  logic [31:0]                addr;
  logic [GrpW-1:0]            data;
  logic [3:0][AddrW-1:0]      bank_addr;
  logic [3:0][31:0]           bank_data;
  logic [3:0]                 bank_we;
  logic                       busy;
  logic                       done;

  modport master (
    output start, lsu_op, lmul, vsew, addr, data,
    input  bank_addr, bank_data, bank_we, busy, done
  );

  modport slave (
    input  start, lsu_op, lmul, vsew, addr, data,
    output bank_addr, bank_data, bank_we, busy, done
  );
endinterface

// File: rtl/v_storeu.sv
// Vector store unit: writes a register-group image into four 32-bit memory banks,
// one 128-bit beat (one word per bank) per cycle at consecutive word addresses.
module v_storeu #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned GrpW  = 512
) (
  input logic        clk_i,
  input logic        rst_ni,
  v_storeu_if.slave  bus
);

  localparam logic [3:0] OpVse8  = 4'd4;
  localparam logic [3:0] OpVse16 = 4'd5;
  localparam logic [3:0] OpVse32 = 4'd6;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic [1:0]            last_q, last_d;
  logic [3:0]            mask_q, mask_d;
  logic [AddrW-1:0]      base_q, base_d;
  logic [GrpW-1:0]       grp_q, grp_d;
  logic [3:0][AddrW-1:0] waddr_q, waddr_d;
  logic [3:0][31:0]      wdata_q, wdata_d;
  logic [3:0]            we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  op_ok;
  logic [1:0]            req_last;
  logic [3:0]            req_mask;
  logic                  unused_ok;

  // vsew has no data effect and only the low AddrW address bits reach the banks.
  assign unused_ok = ^{bus.vsew, bus.addr[31:AddrW]};

  always_comb begin
    op_ok = (bus.lsu_op == OpVse8) || (bus.lsu_op == OpVse16) || (bus.lsu_op == OpVse32);
    case (bus.lmul)
      3'b000:  begin req_last = 2'd0; req_mask = 4'b1111; end
      3'b001:  begin req_last = 2'd1; req_mask = 4'b1111; end
      3'b010:  begin req_last = 2'd3; req_mask = 4'b1111; end
      3'b111:  begin req_last = 2'd0; req_mask = 4'b0011; end
      default: begin req_last = 2'd0; req_mask = 4'b0001; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    mask_d  = mask_q;
    base_d  = base_q;
    grp_d   = grp_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Beat 0 is loaded straight from the request so it appears the cycle after accept.
        if (bus.start && op_ok) begin
          grp_d   = bus.data;
          base_d  = bus.addr[AddrW-1:0];
          last_d  = req_last;
          mask_d  = req_mask;
          beat_d  = 2'd0;
          busy_d  = 1'b1;
          we_d    = req_mask;
          for (int j = 0; j < 4; j++) begin
            waddr_d[j] = bus.addr[AddrW-1:0];
            wdata_d[j] = bus.data[32*j +: 32];
          end
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (beat_q == last_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          beat_d = beat_q + 2'd1;
          we_d   = mask_q;
          for (int j = 0; j < 4; j++) begin
            waddr_d[j] = base_q + AddrW'(beat_d);
            wdata_d[j] = grp_q[int'(beat_d) * 128 + j * 32 +: 32];
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      beat_q  <= '0;
      last_q  <= '0;
      mask_q  <= '0;
      base_q  <= '0;
      grp_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      grp_q   <= grp_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.bank_addr = waddr_q;
  assign bus.bank_data = wdata_q;
  assign bus.bank_we   = we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_v_storeu.sv
// Randomised scoreboard bench for v_storeu: a driver queues expected bank writes and
// completion pulses, a negedge monitor pops and compares them against the DUT outputs.
module tb_v_storeu;
  localparam int unsigned AW = 10;
  localparam logic [3:0] VSE8  = 4'd4;
  localparam logic [3:0] VSE16 = 4'd5;
  localparam logic [3:0] VSE32 = 4'd6;
  localparam logic [3:0] VLSE8 = 4'd7;

  typedef struct {
    bit               is_done;
    int unsigned      cyc;
    logic [3:0]       mask;
    logic [AW-1:0]    addr;
    logic [3:0][31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  v_storeu_if #(.AddrW(AW), .GrpW(512)) bus ();

  v_storeu #(.AddrW(AW), .GrpW(512)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0;
  int nfail  = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] mem [4][1 << AW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: the group size in bits decides beat count and enabled banks.
  function automatic void plan(input logic [2:0] lmul, output int n, output logic [3:0] mask);
    int bits;
    case (lmul)
      3'd0:    bits = 128;
      3'd1:    bits = 256;
      3'd2:    bits = 512;
      3'd7:    bits = 64;
      default: bits = 32;
    endcase
    n    = (bits + 127) / 128;
    mask = (bits >= 128) ? 4'hF : 4'((1 << (bits / 32)) - 1);
  endfunction

  function automatic logic [511:0] rand_grp();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bank_we != 4'b0 || bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {59'd0, bus.bank_we, bus.done}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("event_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("done_flag", 64'(bus.done), 64'(mon_e.is_done));
          check("busy", 64'(bus.busy), 64'd1);
          check("we_mask", 64'(bus.bank_we), mon_e.is_done ? 64'd0 : 64'(mon_e.mask));
          for (int j = 0; j < 4; j++) begin
            if (!mon_e.is_done && mon_e.mask[j]) begin
              check("bank_addr", 64'(bus.bank_addr[j]), 64'(mon_e.addr));
              check("bank_data", 64'(bus.bank_data[j]), 64'(mon_e.data[j]));
              mem[j][bus.bank_addr[j]] = bus.bank_data[j];
            end
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("missing_event_cycle", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end
    end
  end

  // mode 0: plain; 1: re-pulse start during the write; 2: reset after the first beat.
  task automatic issue(input logic [3:0] op, input logic [2:0] lmul, input logic [31:0] addr,
                       input logic [511:0] data, input int mode);
    int n;
    logic [3:0] mask;
    exp_t e;
    int unsigned c;
    plan(lmul, n, mask);
    bus.start  = 1'b1;
    bus.lsu_op = op;
    bus.lmul   = lmul;
    bus.vsew   = 3'($urandom);
    bus.addr   = addr;
    bus.data   = data;
    c = cyc;
    if (op == VSE8 || op == VSE16 || op == VSE32) begin
      for (int k = 0; k < n; k++) begin
        e.is_done = 1'b0;
        e.cyc     = c + 1 + k;
        e.mask    = mask;
        e.addr    = AW'(addr + 32'(k));
        for (int j = 0; j < 4; j++) e.data[j] = data[128*k + 32*j +: 32];
        sb.push_back(e);
      end
      e.is_done = 1'b1;
      e.cyc     = c + 1 + n;
      e.mask    = '0;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.data  = rand_grp();
    bus.addr  = $urandom;
    bus.lmul  = 3'($urandom);
    if (mode == 1) begin
      bus.start  = 1'b1;
      bus.lsu_op = VSE32;
      bus.lmul   = 3'd0;
      @(negedge clk);
      bus.start = 1'b0;
    end else if (mode == 2) begin
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("rst_we", 64'(bus.bank_we), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(bus.busy), 64'd0);
    if (!(op == VSE8 || op == VSE16 || op == VSE32)) repeat (4) @(negedge clk);
  endtask

  logic [511:0] d;
  logic [511:0] ramp;

  initial begin
    bus.start  = 1'b0;
    bus.lsu_op = 4'd0;
    bus.lmul   = 3'd0;
    bus.vsew   = 3'd0;
    bus.addr   = 32'd0;
    bus.data   = '0;
    for (int j = 0; j < 4; j++)
      for (int a = 0; a < (1 << AW); a++) mem[j][a] = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_we", 64'(bus.bank_we), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_addr0", 64'(bus.bank_addr[0]), 64'd0);
    check("reset_data3", 64'(bus.bank_data[3]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    d = '0;
    d[127:0] = 128'h44444444_33333333_22222222_11111111;
    issue(VSE32, 3'b000, 32'h10, d, 0);
    check("hold_data3", 64'(bus.bank_data[3]), 64'h44444444);
    check("hold_addr0", 64'(bus.bank_addr[0]), 64'h10);

    for (int i = 0; i < 16; i++) ramp[32*i +: 32] = 32'h0101_0101 * 32'(i + 1);
    issue(VSE8, 3'b010, 32'h20, ramp, 0);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        check("readback", 64'(mem[j][AW'(32'h20 + 32'(k))]), 64'(ramp[128*k + 32*j +: 32]));

    issue(VSE16, 3'b111, 32'h40, rand_grp(), 0);
    issue(VSE16, 3'b110, 32'h48, rand_grp(), 0);
    check("bank2_untouched", 64'(mem[2][10'h48]), 64'd0);
    issue(VSE32, 3'b010, 32'h60, rand_grp(), 1);
    issue(VLSE8, 3'b000, 32'h70, rand_grp(), 0);
    issue(VSE8, 3'b001, 32'(2 ** AW - 1), rand_grp(), 0);
    issue(VSE32, 3'b010, 32'h80, rand_grp(), 2);
    issue(VSE32, 3'b010, 32'h90, rand_grp(), 0);

    for (int t = 0; t < 40; t++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) != 0) ? 4'(VSE8 + 4'($urandom_range(0, 2)))
                                       : 4'($urandom_range(0, 15));
      issue(op, 3'($urandom_range(0, 7)), $urandom, rand_grp(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
